// File: rtl/voice_mixer_seq.sv
// voice_mixer_seq: averages the active voice samples on each tick using a bit-serial restoring divider.
// Define VOICE_MIXER_MASTER_VOL_EN to add the master_vol port and scale the mean by master_vol/256.
module voice_mixer_seq #(
    parameter int NUM_VOICES = 13,
    parameter int SAMPLE_W   = 8
) (
    input  logic                           clk,
    input  logic                           nRst,
    input  logic                           sample_tick,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voices,
    input  logic [NUM_VOICES-1:0]          active,
`ifdef VOICE_MIXER_MASTER_VOL_EN
    input  logic [7:0]                     master_vol,
`endif
    output logic [SAMPLE_W-1:0]            mixed_sample,
    output logic                           sample_valid,
    output logic                           busy,
    output logic                           overrun
);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);
    localparam int SUM_W = SAMPLE_W + CNT_W;
    localparam int CYC_W = $clog2(NUM_VOICES + SUM_W);
    typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_t;
    state_t                         state_q;
    logic [NUM_VOICES*SAMPLE_W-1:0] voices_q;
    logic [NUM_VOICES-1:0]          active_q;
    logic [SUM_W-1:0]               acc_q;
    logic [CNT_W-1:0]               count_q;
    logic [CNT_W-1:0]               rem_q;
    logic [CYC_W-1:0]               cyc_q;
    logic [SAMPLE_W-1:0]            mixed_q;
    logic                           valid_q;
    logic                           busy_q;
    logic                           overrun_q;
    logic [CNT_W:0]                 trial_d;
    logic [CNT_W:0]                 diff_d;
    logic                           fit_d;
    logic [CNT_W-1:0]               rem_d;
    logic [SAMPLE_W-1:0]            q_d;
    logic [SAMPLE_W-1:0]            mix_d;
    // acc_q holds the dividend and shifts the quotient in from the bottom
    assign trial_d = {rem_q, acc_q[SUM_W-1]};
    assign diff_d  = trial_d - {1'b0, count_q};
    assign fit_d   = trial_d >= {1'b0, count_q};
    assign rem_d   = fit_d ? diff_d[CNT_W-1:0] : trial_d[CNT_W-1:0];
    assign q_d     = (count_q == '0) ? '0 : acc_q[SAMPLE_W-1:0];
`ifdef VOICE_MIXER_MASTER_VOL_EN
    logic [7:0]            vol_q;
    logic [SAMPLE_W+7:0]   prod_d;
    assign prod_d = {8'd0, q_d} * {{SAMPLE_W{1'b0}}, vol_q};
    assign mix_d  = prod_d[SAMPLE_W+7:8];
`else
    assign mix_d = q_d;
`endif
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q   <= IDLE;
            voices_q  <= '0;
            active_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            rem_q     <= '0;
            cyc_q     <= '0;
            mixed_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef VOICE_MIXER_MASTER_VOL_EN
            vol_q     <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (sample_tick && busy_q) overrun_q <= 1'b1;
            case (state_q)
                IDLE: if (sample_tick) begin
                    voices_q <= voices;
                    active_q <= active;
`ifdef VOICE_MIXER_MASTER_VOL_EN
                    vol_q    <= master_vol;
`endif
                    acc_q    <= '0;
                    count_q  <= '0;
                    rem_q    <= '0;
                    cyc_q    <= CYC_W'(NUM_VOICES - 1);
                    busy_q   <= 1'b1;
                    state_q  <= ACCUM;
                end
                ACCUM: begin
                    if (active_q[0]) begin
                        acc_q   <= acc_q + SUM_W'(voices_q[SAMPLE_W-1:0]);
                        count_q <= count_q + 1'b1;
                    end
                    voices_q <= voices_q >> SAMPLE_W;
                    active_q <= active_q >> 1;
                    cyc_q    <= (cyc_q == '0) ? CYC_W'(SUM_W - 1) : cyc_q - 1'b1;
                    state_q  <= (cyc_q == '0) ? DIV : ACCUM;
                end
                DIV: begin
                    acc_q   <= {acc_q[SUM_W-2:0], fit_d};
                    rem_q   <= rem_d;
                    cyc_q   <= cyc_q - 1'b1;
                    state_q <= (cyc_q == '0) ? DONE : DIV;
                end
                default: begin
                    mixed_q <= mix_d;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign mixed_sample = mixed_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_voice_mixer_seq.sv
// tb_voice_mixer_seq: random and directed ticks against an arithmetic mean model; a scoreboard
// queue holds expected mixes and a negedge monitor checks value, latency, busy and overrun.
module tb_voice_mixer_seq;
    localparam int NV  = 13;
    localparam int SW  = 8;
    localparam int LAT = 26;
    typedef struct {int val; int at;} exp_t;
    logic             clk = 1'b0;
    logic             nRst = 1'b0;
    logic             sample_tick = 1'b0;
    logic [NV*SW-1:0] voices = '0;
    logic [NV-1:0]    active = '0;
    logic [7:0]       vol = 8'd0;
    logic [SW-1:0]    mixed_sample;
    logic             sample_valid;
    logic             busy;
    logic             overrun;
    exp_t             sb[$];
    int               edge_n = 0;
    int               busy_end = -1;
    int               pend_edge = -1;
    int               pend_val = 0;
    int               out_m = 0;
    logic             ovr_m = 1'b0;
    logic             chk_en = 1'b0;
    int               errors = 0;
    int               checks = 0;
    voice_mixer_seq #(.NUM_VOICES(NV), .SAMPLE_W(SW)) dut (
        .clk(clk),
        .nRst(nRst),
        .sample_tick(sample_tick),
        .voices(voices),
        .active(active),
`ifdef VOICE_MIXER_MASTER_VOL_EN
        .master_vol(vol),
`endif
        .mixed_sample(mixed_sample),
        .sample_valid(sample_valid),
        .busy(busy),
        .overrun(overrun)
    );
    always #5 clk = ~clk;
    function automatic int mix_ref(input logic [NV*SW-1:0] v, input logic [NV-1:0] a, input int mv);
        int s = 0;
        int n = 0;
        int q;
        for (int i = 0; i < NV; i++) if (a[i]) begin
            s += int'(v[i*SW +: SW]);
            n++;
        end
        q = (n == 0) ? 0 : s / n;
`ifdef VOICE_MIXER_MASTER_VOL_EN
        q = (q * mv) / 256;
`else
        if (mv < 0) q = 0;
`endif
        return q;
    endfunction
    // Model: one mix in flight; a tick is taken only once the previous mix has finished DONE
    always @(posedge clk) begin
        automatic int e = edge_n + 1;
        edge_n <= e;
        if (!nRst) begin
            sb.delete();
            busy_end  <= -1;
            pend_edge <= -1;
            ovr_m     <= 1'b0;
            out_m     <= 0;
        end else begin
            if (e == pend_edge) out_m <= pend_val;
            if (sample_tick) begin
                if (e > busy_end) begin
                    automatic int v = mix_ref(voices, active, int'(vol));
                    sb.push_back('{v, e + LAT});
                    busy_end  <= e + LAT;
                    pend_edge <= e + LAT;
                    pend_val  <= v;
                end else ovr_m <= 1'b1;
            end
        end
    end
    always @(negedge clk) if (chk_en) begin
        checks += 3;
        if (int'(mixed_sample) != out_m) begin
            errors++;
            $display("FAIL hold edge=%0d mixed_sample=%0d want %0d", edge_n, mixed_sample, out_m);
        end
        if (busy !== (edge_n < busy_end)) begin
            errors++;
            $display("FAIL busy edge=%0d got %b want %b", edge_n, busy, edge_n < busy_end);
        end
        if (overrun !== ovr_m) begin
            errors++;
            $display("FAIL overrun edge=%0d got %b want %b", edge_n, overrun, ovr_m);
        end
        if (sample_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_valid edge=%0d got valid want none", edge_n);
            end else begin
                automatic exp_t x = sb.pop_front();
                checks++;
                if (int'(mixed_sample) != x.val || x.at != edge_n) begin
                    errors++;
                    $display("FAIL mix edge=%0d got %0d want %0d at edge %0d", edge_n, mixed_sample, x.val, x.at);
                end
            end
        end else if (sample_valid !== 1'b0 || (sb.size() > 0 && sb[0].at <= edge_n)) begin
            errors++;
            checks++;
            $display("FAIL missing_valid edge=%0d got %b want 1", edge_n, sample_valid);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    end
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic scramble();
        for (int i = 0; i < NV; i++) voices[i*SW +: SW] = SW'($urandom);
        active = NV'($urandom);
        vol = 8'($urandom);
    endtask
    task automatic fire(input logic [NV*SW-1:0] v, input logic [NV-1:0] a, input logic [7:0] mv);
        voices = v;
        active = a;
        vol = mv;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        scramble();
    endtask
    initial begin
        logic [NV*SW-1:0] v;
        @(negedge clk);
        chk_en = 1'b1;
        wait_n(2);
        nRst = 1'b1;
        wait_n(5);
        fire({NV{8'hFF}}, {NV{1'b1}}, 8'hFF);
        wait_n(LAT + 2);
        v = {NV{8'hAA}};
        v[7:0] = 8'd10;
        v[15:8] = 8'd20;
        v[23:16] = 8'd33;
        fire(v, 13'b0_0000_0000_0111, 8'd128);
        wait_n(LAT + 2);
        v[7:0] = 8'd1;
        v[15:8] = 8'd2;
        fire(v, 13'b0_0000_0000_0011, 8'd200);
        wait_n(LAT + 2);
        fire(v, '0, 8'd255);
        wait_n(LAT + 2);
        v = '0;
        v[39:32] = 8'd200;
        fire(v, 13'b0_0000_0001_0000, 8'd128);
        wait_n(LAT + 2);
        fire({NV{8'h7F}}, 13'b1_0101_0101_0101, 8'd64);
        wait_n(4);
        fire({NV{8'h01}}, {NV{1'b1}}, 8'd1);
        wait_n(LAT - 5);
        fire({NV{8'h40}}, 13'b1_0000_0000_0001, 8'd255);
        wait_n(LAT + 2);
        fire({NV{8'h33}}, {NV{1'b1}}, 8'd99);
        wait_n(9);
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        wait_n(LAT + 4);
        for (int k = 0; k < 40; k++) begin
            scramble();
            if (k % 8 == 0) active = '0;
            if (k % 8 == 1) active = '1;
            fire(voices, active, vol);
            wait_n(int'($urandom_range(0, LAT + 6)));
        end
        wait_n(LAT + 4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
